// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: records retiring instructions whose sequence number lies in [START_SEQ, STOP_SEQ].
// Latency: 1 cycle from the commit edge to out_valid. The output is show-ahead from the read pointer.
// Backpressure: out_valid/out_ready. When full, a new entry is dropped (WRAP_MODE=0) or replaces the oldest (WRAP_MODE=1); either case sets the sticky overflow flag.
//
// Optional feature: define TRACE_REGWB_EN to store and present rd / rd_we / rd_data.
// When it is undefined, out_rd, out_rd_we and out_rd_data are tied to 0.
//
// Ports:
//   clk, reset                 : rising-edge clock; asynchronous active-high reset
//   clear                      : synchronous flush of the entries, pointers, seq_count and overflow
//   commit_*                   : one retiring instruction per cycle when commit_valid=1
//   out_valid/out_ready/out_*  : oldest stored entry and consumer handshake
//   count, overflow, seq_count : occupancy, sticky loss flag, and number of commits seen
module commit_trace_buffer #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] START_SEQ = 32'd1,
  parameter logic [31:0] STOP_SEQ  = 32'hFFFF_FFFF,
  parameter bit          WRAP_MODE = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic [4:0]               commit_rd,
  input  logic                     commit_rd_we,
  input  logic [XLEN-1:0]          commit_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_seq,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [4:0]               out_rd,
  output logic                     out_rd_we,
  output logic [XLEN-1:0]          out_rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [31:0]              seq_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] SEQ_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } base_t;

  base_t           base_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [31:0]     seq_num;
  logic            in_window;
  logic            capture;
  logic            pop;
  logic            full;
  logic            do_write;
  logic            drop;
  logic            evict;
  logic            adv_rd;

  // The sequence number sticks at SEQ_MAX once the counter has saturated.
  assign seq_num   = (seq_count == SEQ_MAX) ? SEQ_MAX : seq_count + 32'd1;
  // The comparison is done at 33 bits so that a STOP_SEQ of all-ones stays an ordinary bound.
  assign in_window = ({1'b0, seq_num} >= {1'b0, START_SEQ}) &&
                     ({1'b0, seq_num} <= {1'b0, STOP_SEQ});
  assign capture   = commit_valid && in_window;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == CW'(DEPTH));

  // Full with no pop: WRAP_MODE=0 discards the new entry. WRAP_MODE=1 overwrites the slot at
  // wr_ptr, which equals rd_ptr when the buffer is full. In that case the read pointer is
  // advanced past the lost entry.
  assign drop      = capture && full && !pop && !WRAP_MODE;
  assign evict     = capture && full && !pop &&  WRAP_MODE;
  assign do_write  = capture && !drop;
  assign adv_rd    = pop || evict;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      seq_count <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      seq_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (commit_valid && (seq_count != SEQ_MAX)) begin
        seq_count <= seq_count + 32'd1;
      end
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (adv_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A write together with a read-side advance (a pop or an eviction) leaves occupancy unchanged.
      if (do_write && !adv_rd) begin
        count <= count + 1'b1;
      end else if (!do_write && adv_rd) begin
        count <= count - 1'b1;
      end
      if (drop || evict) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry payload storage has no reset. Occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write) begin
      base_mem[wr_ptr] <= '{seq: seq_num, pc: commit_pc, instr: commit_instr};
    end
  end

  assign out_seq   = base_mem[rd_ptr].seq;
  assign out_pc    = base_mem[rd_ptr].pc;
  assign out_instr = base_mem[rd_ptr].instr;

`ifdef TRACE_REGWB_EN
  typedef struct packed {
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] data;
  } regwb_t;

  regwb_t regwb_mem [DEPTH];

  // Data is stored as zero for instructions that do not write rd.
  always_ff @(posedge clk) begin
    if (do_write) begin
      regwb_mem[wr_ptr] <= '{rd:   commit_rd,
                             we:   commit_rd_we,
                             data: commit_rd_we ? commit_rd_data : '0};
    end
  end

  assign out_rd      = regwb_mem[rd_ptr].rd;
  assign out_rd_we   = regwb_mem[rd_ptr].we;
  assign out_rd_data = regwb_mem[rd_ptr].data;
`else
  logic unused_regwb;
  assign unused_regwb = ^{commit_rd, commit_rd_we, commit_rd_data};

  assign out_rd      = '0;
  assign out_rd_we   = 1'b0;
  assign out_rd_data = '0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
`timescale 1ns/1ps
module tb_commit_trace_buffer;

  localparam int XLEN = 64;
  localparam int D    = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            clear;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [31:0]     commit_instr;
  logic [4:0]      commit_rd;
  logic            commit_rd_we;
  logic [XLEN-1:0] commit_rd_data;
  logic [2:0]      rdy;

  logic [2:0]            o_valid, o_rd_we, o_ovf;
  logic [2:0][31:0]      o_seq, o_instr, o_seqc;
  logic [2:0][XLEN-1:0]  o_pc, o_data;
  logic [2:0][4:0]       o_rd;
  logic [2:0][CW-1:0]    o_cnt;

  // Instance 0: drop mode. Instance 1: wrap mode. Instance 2: drop mode with capture window 30..45.
  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(D), .START_SEQ(32'd1), .WRAP_MODE(1'b0)) u_drop (
    .clk(clk), .reset(reset), .clear(clear), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_rd(commit_rd),
    .commit_rd_we(commit_rd_we), .commit_rd_data(commit_rd_data),
    .out_valid(o_valid[0]), .out_ready(rdy[0]), .out_seq(o_seq[0]), .out_pc(o_pc[0]),
    .out_instr(o_instr[0]), .out_rd(o_rd[0]), .out_rd_we(o_rd_we[0]), .out_rd_data(o_data[0]),
    .count(o_cnt[0]), .overflow(o_ovf[0]), .seq_count(o_seqc[0]));

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(D), .START_SEQ(32'd1), .WRAP_MODE(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_rd(commit_rd),
    .commit_rd_we(commit_rd_we), .commit_rd_data(commit_rd_data),
    .out_valid(o_valid[1]), .out_ready(rdy[1]), .out_seq(o_seq[1]), .out_pc(o_pc[1]),
    .out_instr(o_instr[1]), .out_rd(o_rd[1]), .out_rd_we(o_rd_we[1]), .out_rd_data(o_data[1]),
    .count(o_cnt[1]), .overflow(o_ovf[1]), .seq_count(o_seqc[1]));

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(D), .START_SEQ(32'd30), .STOP_SEQ(32'd45),
                        .WRAP_MODE(1'b0)) u_win (
    .clk(clk), .reset(reset), .clear(clear), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_rd(commit_rd),
    .commit_rd_we(commit_rd_we), .commit_rd_data(commit_rd_data),
    .out_valid(o_valid[2]), .out_ready(rdy[2]), .out_seq(o_seq[2]), .out_pc(o_pc[2]),
    .out_instr(o_instr[2]), .out_rd(o_rd[2]), .out_rd_we(o_rd_we[2]), .out_rd_data(o_data[2]),
    .count(o_cnt[2]), .overflow(o_ovf[2]), .seq_count(o_seqc[2]));

  // Behavioural reference: one queue of entries per instance, plus a shared commit counter.
  typedef struct {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq [3][$];
  bit   [2:0]      movf;
  longint unsigned mseqc;
  longint unsigned start_k [3] = '{1, 1, 30};
  longint unsigned stop_k  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 45};
  bit              wrap_k  [3] = '{1'b0, 1'b1, 1'b0};

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
    end
    mseqc = 0;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid%0d", k), 64'(o_valid[k]), 64'(mq[k].size() != 0));
      chk($sformatf("count%0d", k), 64'(o_cnt[k]), 64'(mq[k].size()));
      chk($sformatf("ovf%0d", k), 64'(o_ovf[k]), 64'(movf[k]));
      chk($sformatf("seqc%0d", k), 64'(o_seqc[k]), mseqc);
      if (mq[k].size() != 0) begin
        chk($sformatf("seq%0d", k), 64'(o_seq[k]), 64'(mq[k][0].seq));
        chk($sformatf("pc%0d", k), o_pc[k], mq[k][0].pc);
        chk($sformatf("instr%0d", k), 64'(o_instr[k]), 64'(mq[k][0].instr));
`ifdef TRACE_REGWB_EN
        chk($sformatf("rd%0d", k), 64'(o_rd[k]), 64'(mq[k][0].rd));
        chk($sformatf("rdwe%0d", k), 64'(o_rd_we[k]), 64'(mq[k][0].we));
        chk($sformatf("rddata%0d", k), o_data[k], mq[k][0].data);
`endif
      end
`ifndef TRACE_REGWB_EN
      chk($sformatf("rdzero%0d", k), {57'd0, o_rd[k], o_rd_we[k], 1'b0} | o_data[k], 64'd0);
`endif
    end
  endtask

  // Drive one cycle, advance the model with the pre-edge inputs, then check after the edge.
  task automatic step(input bit clr, input bit cv, input logic [2:0] r,
                      input logic [XLEN-1:0] pc, input logic [31:0] instr,
                      input logic [4:0] rd, input bit we, input logic [XLEN-1:0] data);
    clear = clr; commit_valid = cv; rdy = r;
    commit_pc = pc; commit_instr = instr; commit_rd = rd;
    commit_rd_we = we; commit_rd_data = data;
    if (clr) begin
      model_clear();
    end else begin
      longint unsigned sn;
      ent_t e;
      sn = (mseqc >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mseqc + 1;
      e.seq = sn[31:0]; e.pc = pc; e.instr = instr;
      e.rd = rd; e.we = we; e.data = we ? data : '0;
      for (int k = 0; k < 3; k++) begin
        if (r[k] && mq[k].size() != 0) void'(mq[k].pop_front());
        if (cv && sn >= start_k[k] && sn <= stop_k[k]) begin
          if (mq[k].size() < D) begin
            mq[k].push_back(e);
          end else begin
            movf[k] = 1'b1;
            if (wrap_k[k]) begin
              void'(mq[k].pop_front());
              mq[k].push_back(e);
            end
          end
        end
      end
      if (cv) mseqc = sn;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset is asserted between clock edges. The cleared state must be visible before the next edge.
  task automatic pulse_reset();
    clear = 1'b0; commit_valid = 1'b0; rdy = '0;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid%0d", k), 64'(o_valid[k]), 64'd0);
      chk($sformatf("rst_seqc%0d", k), 64'(o_seqc[k]), 64'd0);
    end
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit clr, cv, rdy;
    int cnt0, ovf0, head0, cnt1, ovf1, head1, seqc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit clr, input bit cv, input bit r, input int c0, input int v0,
                     input int h0, input int c1, input int v1, input int h1, input int sc);
    vec_t v;
    v.clr = clr; v.cv = cv; v.rdy = r;
    v.cnt0 = c0; v.ovf0 = v0; v.head0 = h0;
    v.cnt1 = c1; v.ovf1 = v1; v.head1 = h1; v.seqc = sc;
    tv.push_back(v);
  endtask

  logic [31:0] got_seq [$];
  logic [63:0] got_pc  [$];

  initial begin
    //  clr cv rdy | drop: cnt ovf head | wrap: cnt ovf head | seq_count
    add(0, 1, 0,   1, 0, 1,   1, 0, 1,   1);
    add(0, 1, 0,   2, 0, 1,   2, 0, 1,   2);
    add(0, 1, 0,   3, 0, 1,   3, 0, 1,   3);
    add(0, 1, 0,   4, 0, 1,   4, 0, 1,   4);
    add(0, 1, 0,   4, 1, 1,   4, 1, 2,   5);
    add(0, 1, 0,   4, 1, 1,   4, 1, 3,   6);
    add(0, 1, 1,   4, 1, 2,   4, 1, 4,   7);  // full: commit and pop in the same cycle
    add(0, 0, 1,   3, 1, 3,   3, 1, 5,   7);
    add(0, 0, 1,   2, 1, 4,   2, 1, 6,   7);
    add(0, 0, 1,   1, 1, 7,   1, 1, 7,   7);
    add(0, 0, 1,   0, 1, 0,   0, 1, 0,   7);
    add(0, 0, 1,   0, 1, 0,   0, 1, 0,   7);  // ready while empty
    add(1, 1, 0,   0, 0, 0,   0, 0, 0,   0);  // clear beats commit
    add(0, 1, 0,   1, 0, 1,   1, 0, 1,   1);
    add(1, 0, 0,   0, 0, 0,   0, 0, 0,   0);

    reset = 1'b1; clear = 1'b0; commit_valid = 1'b0; rdy = '0;
    commit_pc = '0; commit_instr = '0; commit_rd = '0; commit_rd_we = 1'b0; commit_rd_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all();

    // Table-driven sequence covering drop, wrap, full pop+commit, drain and clear.
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].clr, tv[i].cv, {1'b1, tv[i].rdy, tv[i].rdy}, 64'h100 + 64'(4 * i),
           32'h0000_0013, 5'(i), i[0], 64'($urandom));
      chk($sformatf("tv%0d_cnt0", i), 64'(o_cnt[0]), 64'(tv[i].cnt0));
      chk($sformatf("tv%0d_ovf0", i), 64'(o_ovf[0]), 64'(tv[i].ovf0));
      chk($sformatf("tv%0d_cnt1", i), 64'(o_cnt[1]), 64'(tv[i].cnt1));
      chk($sformatf("tv%0d_ovf1", i), 64'(o_ovf[1]), 64'(tv[i].ovf1));
      chk($sformatf("tv%0d_seqc", i), 64'(o_seqc[0]), 64'(tv[i].seqc));
      if (tv[i].cnt0 != 0) chk($sformatf("tv%0d_head0", i), 64'(o_seq[0]), 64'(tv[i].head0));
      if (tv[i].cnt1 != 0) chk($sformatf("tv%0d_head1", i), 64'(o_seq[1]), 64'(tv[i].head1));
    end

    // Write-back fields (addi x5, x0, 42), then a reset in the middle of the stream.
    pulse_reset();
    step(0, 1, 3'b000, 64'h2000, 32'h02A0_0293, 5'd5, 1'b1, 64'h2A);
`ifdef TRACE_REGWB_EN
    chk("addi_rd", 64'(o_rd[0]), 64'd5);
    chk("addi_data", o_data[0], 64'h2A);
`else
    chk("addi_rd_off", 64'(o_rd[0]), 64'd0);
    chk("addi_data_off", o_data[0], 64'd0);
`endif
    step(0, 1, 3'b000, 64'h2004, 32'h0000_0013, 5'd6, 1'b0, 64'h55);
    pulse_reset();
    step(0, 1, 3'b000, 64'h2008, 32'h0000_0013, 5'd7, 1'b1, 64'h77);
    chk("post_rst_seq", 64'(o_seq[0]), 64'd1);

    // Capture window 30..45 with a consumer that is always ready.
    pulse_reset();
    for (int n = 0; n < 45; n++) begin
      step(0, 1, 3'b100, 64'(4 * n), 32'h0000_0013, 5'd1, 1'b1, 64'(n));
      if (o_valid[2]) begin
        got_seq.push_back(o_seq[2]);
        got_pc.push_back(o_pc[2]);
      end
    end
    step(0, 0, 3'b100, '0, '0, '0, 1'b0, '0);
    chk("win_count", 64'(got_seq.size()), 64'd16);
    if (got_seq.size() == 16) begin
      chk("win_first_pc", got_pc[0], 64'h74);
      chk("win_last_pc", got_pc[15], 64'hB0);
      for (int j = 0; j < 16; j++) chk($sformatf("win_seq%0d", j), 64'(got_seq[j]), 64'(30 + j));
    end

    // Same window with the consumer stalled: the buffer fills and overflow is set.
    pulse_reset();
    for (int n = 0; n < 45; n++)
      step(0, 1, 3'b000, 64'(4 * n), 32'h0000_0013, 5'd1, 1'b1, 64'(n));
    chk("win_stall_ovf", 64'(o_ovf[2]), 64'd1);
    chk("win_stall_cnt", 64'(o_cnt[2]), 64'd4);
    chk("win_stall_pc", o_pc[2], 64'h74);

    // Randomized traffic against the reference model.
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 3'($urandom),
           {32'($urandom), 32'($urandom)}, 32'($urandom), 5'($urandom),
           1'($urandom), {32'($urandom), 32'($urandom)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter XLEN, default 64: width of PC and register write-back data.
REQ-002 Parameter DEPTH, default 16: trace entries stored; power of two, at least 2.
REQ-003 Parameter START_SEQ, default 1: first commit sequence number captured.
REQ-004 Parameter STOP_SEQ, default 32'hFFFFFFFF: last commit sequence number captured (inclusive).
REQ-005 Parameter WRAP_MODE, default 0: 0 = drop new entries when full; 1 = overwrite the oldest entry.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 clear  input  1  synchronous flush of the buffer, counter and flags.
REQ-009 commit_valid  input  1  one instruction retires this cycle.
REQ-010 commit_pc  input  XLEN  PC of the retiring instruction.
REQ-011 commit_instr  input  32  encoding of the retiring instruction.
REQ-012 commit_rd  input  5  destination register index.
REQ-013 commit_rd_we  input  1  retiring instruction writes rd.
REQ-014 commit_rd_data  input  XLEN  write-back value.
REQ-015 out_valid  output  1  oldest stored entry is presented.
REQ-016 out_ready  input  1  consumer accepts the presented entry.
REQ-017 out_seq  output  32  sequence number of the presented entry.
REQ-018 out_pc / out_instr / out_rd / out_rd_we / out_rd_data  outputs  XLEN/32/5/1/XLEN  fields of the presented entry.
REQ-019 count  output  clog2(DEPTH)+1  entries currently stored.
REQ-020 overflow  output  1  sticky: at least one entry was dropped or overwritten.
REQ-021 seq_count  output  32  commits seen since reset or clear.

Function
REQ-022 seq_count SHALL increment by 1 on each cycle with commit_valid=1 and SHALL saturate at 32'hFFFFFFFF.
REQ-023 The sequence number of a commit SHALL be seq_count+1, saturating at 32'hFFFFFFFF.
REQ-024 A commit SHALL be captured only if START_SEQ <= its sequence number <= STOP_SEQ.
REQ-025 Storage SHALL be a circular buffer with write pointer, read pointer and count, and pointers SHALL wrap modulo DEPTH.
REQ-026 Output SHALL be show-ahead: out_valid = (count != 0), and out_* SHALL combinationally reflect the entry at the read pointer.
REQ-027 A pop SHALL occur on a rising edge with out_valid=1 and out_ready=1, advancing the read pointer.
REQ-028 A captured entry SHALL appear on out_* with out_valid=1 in the cycle after its commit edge, giving a latency of 1.
REQ-029 Capture and pop in the same cycle SHALL leave count unchanged, including when the buffer is full.
REQ-030 Full with no pop and WRAP_MODE=0: the new entry SHALL be discarded, count SHALL hold at DEPTH and overflow SHALL be set.
REQ-031 Full with no pop and WRAP_MODE=1: the new entry SHALL overwrite the oldest, both pointers SHALL advance, count SHALL hold at DEPTH and overflow SHALL be set.
REQ-032 out_ready while empty SHALL have no effect.
REQ-033 clear SHALL take priority over capture and pop: count, pointers, seq_count and overflow SHALL go to 0 at the next edge, and a commit in the same cycle SHALL NOT be counted.
REQ-034 Entries with commit_rd_we=0 SHALL store out_rd_data as 0.

Reset
REQ-035 Asserting reset SHALL immediately clear the pointers, count, seq_count and overflow to 0, forcing out_valid=0.
REQ-036 Entry storage SHALL NOT require reset; out_* data outputs are don't-care while out_valid=0.
REQ-037 Reset asserted mid-operation SHALL discard all stored entries, and the first commit after release SHALL have sequence number 1.

Configuration
REQ-038 With macro TRACE_REGWB_EN defined, each entry SHALL store commit_rd, commit_rd_we and commit_rd_data, presented per REQ-018.
REQ-039 With TRACE_REGWB_EN undefined, the rd fields SHALL NOT be stored, and out_rd, out_rd_we and out_rd_data SHALL be constant 0.

Verification
REQ-040 DEPTH=4, START_SEQ=30, STOP_SEQ=45, 45 commits with PC = 4*n -> exactly 16 entries offered with out_seq 30..45; first out_pc = 0x74, last out_pc = 0xB0; overflow=1 once the buffer fills with out_ready=0.
REQ-041 DEPTH=4, WRAP_MODE=0, 6 commits, out_ready=0 -> count=4, overflow=1; drain yields seq 1..4.
REQ-042 DEPTH=4, WRAP_MODE=1, 6 commits, out_ready=0 -> count=4, overflow=1; drain yields seq 3..6.
REQ-043 Full buffer, commit and out_ready=1 in the same cycle -> count stays 4, overflow unchanged; drain order stays intact.
REQ-044 Commit of addi x5 with rd_data=0x2A, then reset pulse mid-stream -> out_valid=0 immediately, seq_count=0; the next commit gets out_seq=1.
REQ-045 clear and commit_valid in the same cycle -> count=0, seq_count=0, overflow=0 after the edge.
